ahb_bus_arbiter: RTL



---
 rtl/ahb_arb_pkg.sv | 17 +
 rtl/ahb_arb_pick.sv | 40 ++++
 rtl/ahb_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bus arbiter.
package ahb_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    PARK    = 2'd0,
    OWNED   = 2'd1,
    HANDOFF = 2'd2
  } arb_state_t;

  // Next index modulo n, without a divider.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational winner picker: highest eligible index, or first eligible from start (round-robin).
module ahb_arb_pick #(
  parameter int unsigned N           = 2,
  parameter int unsigned MW          = 1,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [MW-1:0] start,
  output logic          valid,
  output logic [MW-1:0] index
);

  logic [N-1:0] elig;
  logic [N-1:0] rot;
  logic         found;

  assign elig  = req & ~mask;
  assign valid = |elig;

  always_comb begin
    index = '0;
    found = 1'b0;
    // Rotate so bit 0 of rot is the master at the start pointer.
    rot   = N'({elig, elig} >> start);
    if (ROUND_ROBIN) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && rot[k]) begin
          found = 1'b1;
          index = MW'((32'(start) + k) % N);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (elig[k]) index = MW'(k);
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot grant, address/data-phase owner indices, parking and tenure limit.
// Define ARB_ROUND_ROBIN_EN to replace fixed highest-index priority with round-robin.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_TENURE     = 16,
  parameter int unsigned MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] bus_req,
  input  logic [NUM_MASTERS-1:0] hold_req,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] bus_grant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   parked
);

  import ahb_arb_pkg::*;

  localparam int unsigned     TW       = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [TW-1:0]   TEN_LAST = TW'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);
  localparam logic [MW-1:0]   DEF_IDX  = MW'(DEFAULT_MASTER);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t             state, state_nxt;
  logic [MW-1:0]          owner_nxt;
  logic [TW-1:0]          tenure, tenure_nxt;
  logic [MW-1:0]          rr_ptr;
  logic [NUM_MASTERS-1:0] own_oh, prev_oh, pick_mask;
  logic                   own_req, own_hold;
  logic                   pick_valid;
  logic [MW-1:0]          pick_idx;

  assign own_oh   = NUM_MASTERS'(1) << hmaster;
  assign prev_oh  = NUM_MASTERS'(1) << hmaster_data;
  assign own_req  = |(bus_req & own_oh);
  assign own_hold = |(hold_req & own_oh);

  // The owner is never its own successor; in HANDOFF hmaster_data still names the previous owner.
  always_comb begin
    pick_mask = '0;
    if (state != PARK) begin
      pick_mask = own_oh;
      if (state == HANDOFF && own_req) pick_mask = own_oh | prev_oh;
    end
  end

  ahb_arb_pick #(
    .N           (NUM_MASTERS),
    .MW          (MW),
    .ROUND_ROBIN (RR_EN)
  ) u_pick (
    .req   (bus_req),
    .mask  (pick_mask),
    .start (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Next-state and next-owner decision, committed only on hready edges.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = hmaster;
    tenure_nxt = (tenure == TEN_LAST) ? tenure : tenure + 1'b1;
    case (state)
      PARK: begin
        owner_nxt = DEF_IDX;
        if (pick_valid) begin
          state_nxt  = OWNED;
          owner_nxt  = pick_idx;
          tenure_nxt = '0;
        end
      end
      OWNED, HANDOFF: begin
        state_nxt = OWNED;
        if (own_hold) begin
          state_nxt = OWNED;
        end else if (!own_req) begin
          tenure_nxt = '0;
          if (pick_valid) begin
            owner_nxt = pick_idx;
          end else begin
            state_nxt = PARK;
            owner_nxt = DEF_IDX;
          end
        end else if (!RR_EN && pick_valid && (pick_idx > hmaster)) begin
          owner_nxt  = pick_idx;
          tenure_nxt = '0;
        end else if ((MAX_TENURE > 0) && (tenure == TEN_LAST) && pick_valid) begin
          state_nxt  = HANDOFF;
          owner_nxt  = pick_idx;
          tenure_nxt = '0;
        end
      end
      default: begin
        state_nxt  = PARK;
        owner_nxt  = DEF_IDX;
        tenure_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PARK;
      bus_grant    <= NUM_MASTERS'(1) << DEF_IDX;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      parked       <= 1'b1;
      tenure       <= '0;
    end else if (hready) begin
      state        <= state_nxt;
      bus_grant    <= NUM_MASTERS'(1) << owner_nxt;
      hmaster      <= owner_nxt;
      hmaster_data <= hmaster;
      parked       <= (state_nxt == PARK);
      tenure       <= tenure_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Search starts just after the most recent owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hready && (state_nxt != PARK)) begin
      rr_ptr <= MW'(wrap_inc(32'(owner_nxt), NUM_MASTERS));
    end
  end
`else
  assign rr_ptr = '0;
`endif

endmodule
